// File: rtl/bp_me_wormhole_arbiter.sv
// rtl/bp_me_wormhole_arbiter.sv - wormhole link arbiter, round-robin header arbitration with packet locking
// Define BP_ME_WH_ARB_FIXED_PRIO_EN for fixed-priority (lowest index) header arbitration.
module bp_me_wormhole_arbiter #(
  parameter int num_req_p    = 2,
  parameter int flit_width_p = 64,
  parameter int cord_width_p = 8,
  parameter int len_width_p  = 4
) (
  input  logic                                   clk_i,
  input  logic                                   reset_i,
  input  logic [num_req_p-1:0][flit_width_p-1:0] data_i,
  input  logic [num_req_p-1:0]                   v_i,
  output logic [num_req_p-1:0]                   ready_and_o,
  output logic [flit_width_p-1:0]                data_o,
  output logic                                   v_o,
  input  logic                                   ready_and_i,
  output logic [num_req_p-1:0]                   grant_o,
  output logic                                   busy_o
);

  localparam int ptr_width_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1;

  typedef enum logic {e_idle, e_busy} state_e;

  state_e                  state_r, state_n;
  logic [len_width_p-1:0]  count_r, count_n;
  logic [ptr_width_lp-1:0] owner_r, owner_n;
  logic [ptr_width_lp-1:0] arb_idx, sel_idx, k;
  logic [num_req_p-1:0]    arb_grant;
  logic [len_width_p-1:0]  hdr_len;
  logic                    in_busy, hs;

`ifdef BP_ME_WH_ARB_FIXED_PRIO_EN
  // Descending scan so the lowest valid index is the last writer.
  always_comb begin
    arb_grant = '0;
    arb_idx   = '0;
    k         = '0;
    for (int i = num_req_p - 1; i >= 0; i--) begin
      k = ptr_width_lp'(i);
      if (v_i[k]) begin
        arb_grant    = '0;
        arb_grant[k] = 1'b1;
        arb_idx      = k;
      end
    end
  end
`else
  logic [ptr_width_lp-1:0] last_ptr_r, last_ptr_n;

  // Scan offsets from far to near so the requester right after last_ptr wins.
  always_comb begin
    arb_grant = '0;
    arb_idx   = '0;
    k         = '0;
    for (int i = num_req_p; i >= 1; i--) begin
      k = ptr_width_lp'((int'(last_ptr_r) + i) % num_req_p);
      if (v_i[k]) begin
        arb_grant    = '0;
        arb_grant[k] = 1'b1;
        arb_idx      = k;
      end
    end
  end
`endif

  // Reset forces the idle view of the outputs even while the state register is still busy.
  always_comb begin
    in_busy = (state_r == e_busy) && !reset_i;
    sel_idx = in_busy ? owner_r : arb_idx;
    grant_o = '0;
    if (in_busy) grant_o[owner_r] = 1'b1;
    else         grant_o = arb_grant;
    data_o      = data_i[sel_idx];
    v_o         = in_busy ? v_i[owner_r] : |v_i;
    ready_and_o = grant_o & {num_req_p{ready_and_i}};
    busy_o      = in_busy;
    hs          = v_o & ready_and_i;
    hdr_len     = data_o[cord_width_p +: len_width_p];
  end

  always_comb begin
    state_n = state_r;
    count_n = count_r;
    owner_n = owner_r;
`ifndef BP_ME_WH_ARB_FIXED_PRIO_EN
    last_ptr_n = last_ptr_r;
`endif
    if (hs) begin
      case (state_r)
        e_idle: begin
`ifndef BP_ME_WH_ARB_FIXED_PRIO_EN
          last_ptr_n = arb_idx;
`endif
          if (hdr_len != '0) begin
            count_n = hdr_len;
            owner_n = arb_idx;
            state_n = e_busy;
          end
        end
        e_busy: begin
          count_n = count_r - 1'b1;
          if (count_r == len_width_p'(1)) state_n = e_idle;
        end
        default: state_n = e_idle;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r <= e_idle;
      count_r <= '0;
      owner_r <= '0;
`ifndef BP_ME_WH_ARB_FIXED_PRIO_EN
      last_ptr_r <= ptr_width_lp'(num_req_p - 1);
`endif
    end else begin
      state_r <= state_n;
      count_r <= count_n;
      owner_r <= owner_n;
`ifndef BP_ME_WH_ARB_FIXED_PRIO_EN
      last_ptr_r <= last_ptr_n;
`endif
    end
  end

endmodule

// File: tb/tb_bp_me_wormhole_arbiter.sv
// tb/tb_bp_me_wormhole_arbiter.sv - scoreboard bench for the wormhole link arbiter
module tb_bp_me_wormhole_arbiter;

  logic            clk = 1'b0;
  logic            reset_i;
  logic [1:0][63:0] data_i;
  logic [1:0]      v_i;
  logic [1:0]      ready_and_o;
  logic [63:0]     data_o;
  logic            v_o;
  logic            ready_and_i;
  logic [1:0]      grant_o;
  logic            busy_o;

  int          passed = 0;
  int          total  = 0;
  logic [63:0] exp_q[$];
  logic [63:0] sb_exp;
  logic [5:0]  obs;

  bp_me_wormhole_arbiter dut (
    .clk_i(clk), .reset_i(reset_i), .data_i(data_i), .v_i(v_i),
    .ready_and_o(ready_and_o), .data_o(data_o), .v_o(v_o),
    .ready_and_i(ready_and_i), .grant_o(grant_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  assign obs = {grant_o, ready_and_o, v_o, busy_o};

  // Every handshake on the shared link must deliver the next expected flit.
  always @(negedge clk) begin
    if (!reset_i && v_o && ready_and_i) begin
      total++;
      if (exp_q.size() == 0) begin
        $display("FAIL sb_unexpected data_o=%h expected=none", data_o);
      end else begin
        sb_exp = exp_q.pop_front();
        if (data_o !== sb_exp) $display("FAIL sb_data data_o=%h expected=%h", data_o, sb_exp);
        else passed++;
      end
    end
  end

  function automatic logic [63:0] mk(input int req, input int seq, input int len);
    logic [63:0] f;
    f = '0;
    f[63:56] = 8'(req);
    f[55:40] = 16'(seq);
    f[39:32] = 8'h5a;
    f[11:8]  = 4'(len);
    f[7:0]   = 8'(req);
    return f;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset_i = 1'b1; v_i = 2'b00; data_i = '0; ready_and_i = 1'b1;
    tick; tick;
    #1;
    total++;
    if (obs !== 6'b00_00_0_0) $display("FAIL reset_idle obs=%b expected=%b", obs, 6'b00_00_0_0);
    else passed++;
    v_i = 2'b11;
    #1;
    total++;
    if (obs !== 6'b01_01_1_0) $display("FAIL reset_prio obs=%b expected=%b", obs, 6'b01_01_1_0);
    else passed++;
    reset_i = 1'b0; v_i = 2'b00;
    tick;
  endtask

  task automatic test_round_robin;
    logic [5:0] e;
    for (int c = 0; c < 4; c++) begin
      data_i[0] = mk(0, c, 0); data_i[1] = mk(1, c, 0); v_i = 2'b11;
      #1;
      e = (c % 2 == 0) ? 6'b01_01_1_0 : 6'b10_10_1_0;
      total++;
      if (obs !== e) $display("FAIL rr_c%0d obs=%b expected=%b", c, obs, e);
      else passed++;
      exp_q.push_back((c % 2 == 0) ? data_i[0] : data_i[1]);
      tick;
    end
  endtask

  task automatic test_fixed_prio;
    for (int c = 0; c < 4; c++) begin
      data_i[0] = mk(0, c, 0); data_i[1] = mk(1, c, 0); v_i = 2'b11;
      #1;
      total++;
      if (obs !== 6'b01_01_1_0) $display("FAIL fixed_c%0d obs=%b expected=%b", c, obs, 6'b01_01_1_0);
      else passed++;
      exp_q.push_back(data_i[0]);
      tick;
    end
  endtask

  task automatic test_packet;
    data_i[1] = mk(1, 0, 3); v_i = 2'b10;
    #1;
    total++;
    if (obs !== 6'b10_10_1_0) $display("FAIL pkt_hdr obs=%b expected=%b", obs, 6'b10_10_1_0);
    else passed++;
    exp_q.push_back(data_i[1]);
    tick;
    for (int b = 1; b <= 3; b++) begin
      data_i[1] = mk(1, b, b + 7); data_i[0] = mk(0, 9, 0); v_i = 2'b11;
      #1;
      total++;
      if (obs !== 6'b10_10_1_1) $display("FAIL pkt_body%0d obs=%b expected=%b", b, obs, 6'b10_10_1_1);
      else passed++;
      exp_q.push_back(data_i[1]);
      tick;
    end
    data_i[0] = mk(0, 10, 0); v_i = 2'b01;
    #1;
    total++;
    if (obs !== 6'b01_01_1_0) $display("FAIL pkt_next obs=%b expected=%b", obs, 6'b01_01_1_0);
    else passed++;
    exp_q.push_back(data_i[0]);
    tick;
  endtask

  task automatic test_stall;
    data_i[0] = mk(0, 20, 3); v_i = 2'b01;
    #1;
    total++;
    if (obs !== 6'b01_01_1_0) $display("FAIL stall_hdr obs=%b expected=%b", obs, 6'b01_01_1_0);
    else passed++;
    exp_q.push_back(data_i[0]);
    tick;
    data_i[0] = mk(0, 21, 9); data_i[1] = mk(1, 21, 0); v_i = 2'b11;
    #1;
    total++;
    if (obs !== 6'b01_01_1_1) $display("FAIL stall_b1 obs=%b expected=%b", obs, 6'b01_01_1_1);
    else passed++;
    exp_q.push_back(data_i[0]);
    tick;
    data_i[0] = mk(0, 22, 9); ready_and_i = 1'b0;
    for (int s = 0; s < 3; s++) begin
      #1;
      total++;
      if (obs !== 6'b01_00_1_1) $display("FAIL stall_hold%0d obs=%b expected=%b", s, obs, 6'b01_00_1_1);
      else passed++;
      tick;
    end
    ready_and_i = 1'b1;
    for (int b = 0; b < 2; b++) begin
      data_i[0] = mk(0, 22 + b, 9);
      #1;
      total++;
      if (obs !== 6'b01_01_1_1) $display("FAIL stall_resume%0d obs=%b expected=%b", b, obs, 6'b01_01_1_1);
      else passed++;
      exp_q.push_back(data_i[0]);
      tick;
    end
    data_i[1] = mk(1, 30, 0); v_i = 2'b10;
    #1;
    total++;
    if (obs !== 6'b10_10_1_0) $display("FAIL stall_done obs=%b expected=%b", obs, 6'b10_10_1_0);
    else passed++;
    exp_q.push_back(data_i[1]);
    tick;
  endtask

  task automatic test_bubble;
    data_i[0] = mk(0, 50, 2); v_i = 2'b01;
    #1;
    total++;
    if (obs !== 6'b01_01_1_0) $display("FAIL bub_hdr obs=%b expected=%b", obs, 6'b01_01_1_0);
    else passed++;
    exp_q.push_back(data_i[0]);
    tick;
    data_i[1] = mk(1, 51, 0); v_i = 2'b10;
    for (int s = 0; s < 2; s++) begin
      #1;
      total++;
      if (obs !== 6'b01_01_0_1) $display("FAIL bub_gap%0d obs=%b expected=%b", s, obs, 6'b01_01_0_1);
      else passed++;
      tick;
    end
    for (int b = 0; b < 2; b++) begin
      data_i[0] = mk(0, 52 + b, 12); v_i = 2'b11;
      #1;
      total++;
      if (obs !== 6'b01_01_1_1) $display("FAIL bub_body%0d obs=%b expected=%b", b, obs, 6'b01_01_1_1);
      else passed++;
      exp_q.push_back(data_i[0]);
      tick;
    end
    v_i = 2'b10;
    #1;
    total++;
    if (obs !== 6'b10_10_1_0) $display("FAIL bub_next obs=%b expected=%b", obs, 6'b10_10_1_0);
    else passed++;
    exp_q.push_back(data_i[1]);
    tick;
  endtask

  task automatic test_reset_mid_packet;
    data_i[0] = mk(0, 40, 7); v_i = 2'b01;
    #1;
    exp_q.push_back(data_i[0]);
    tick;
    for (int b = 0; b < 2; b++) begin
      data_i[0] = mk(0, 41 + b, 3); data_i[1] = mk(1, 41, 0); v_i = 2'b11;
      #1;
      total++;
      if (obs !== 6'b01_01_1_1) $display("FAIL rst_body%0d obs=%b expected=%b", b, obs, 6'b01_01_1_1);
      else passed++;
      exp_q.push_back(data_i[0]);
      tick;
    end
    reset_i = 1'b1;
    #1;
    total++;
    if ({busy_o, v_o} !== 2'b01) $display("FAIL rst_during busy_v=%b expected=%b", {busy_o, v_o}, 2'b01);
    else passed++;
    tick;
    reset_i = 1'b0; data_i[0] = mk(0, 45, 0); data_i[1] = mk(1, 45, 0); v_i = 2'b11;
    #1;
    total++;
    if (obs !== 6'b01_01_1_0) $display("FAIL rst_after obs=%b expected=%b", obs, 6'b01_01_1_0);
    else passed++;
    exp_q.push_back(data_i[0]);
    tick;
  endtask

  task automatic test_max_len;
    data_i[1] = mk(1, 60, 15); v_i = 2'b10;
    #1;
    total++;
    if (obs !== 6'b10_10_1_0) $display("FAIL max_hdr obs=%b expected=%b", obs, 6'b10_10_1_0);
    else passed++;
    exp_q.push_back(data_i[1]);
    tick;
    for (int b = 1; b <= 15; b++) begin
      data_i[1] = mk(1, 60 + b, b); data_i[0] = mk(0, 80, 0); v_i = 2'b11;
      #1;
      total++;
      if (obs !== 6'b10_10_1_1) $display("FAIL max_body%0d obs=%b expected=%b", b, obs, 6'b10_10_1_1);
      else passed++;
      exp_q.push_back(data_i[1]);
      tick;
    end
    v_i = 2'b01;
    #1;
    total++;
    if (obs !== 6'b01_01_1_0) $display("FAIL max_done obs=%b expected=%b", obs, 6'b01_01_1_0);
    else passed++;
    exp_q.push_back(data_i[0]);
    tick;
  endtask

  initial begin
    test_reset;
`ifdef BP_ME_WH_ARB_FIXED_PRIO_EN
    test_fixed_prio;
`else
    test_round_robin;
`endif
    test_packet;
    test_stall;
    test_bubble;
    test_reset_mid_packet;
    test_max_len;
    v_i = 2'b00;
    tick; tick;
    total++;
    if (exp_q.size() != 0) $display("FAIL sb_drain left=%0d expected=0", exp_q.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/bp_me_wormhole_arbiter.md
BP_ME_WORMHOLE_ARBITER -- requirements
Module: bp_me_wormhole_arbiter

Interface
REQ-001 SHALL have parameter num_req_p, default 2: number of tile-side requester links (2..8).
REQ-002 SHALL have parameter flit_width_p, default 64: wormhole flit width in bits.
REQ-003 SHALL have parameter cord_width_p, default 8: header cord field width; the cord field occupies header bits [cord_width_p-1:0].
REQ-004 SHALL have parameter len_width_p, default 4: header len field width; the len field occupies header bits [cord_width_p+:len_width_p] and gives the body flit count.
REQ-005 SHALL use one clock and a synchronous, active-high reset.
REQ-006 clk_i  input  1  clock; all state updates on its rising edge.
REQ-007 reset_i  input  1  synchronous active-high reset.
REQ-008 data_i  input  num_req_p x flit_width_p  requester flits.
REQ-009 v_i  input  num_req_p  requester valid.
REQ-010 ready_and_o  output  num_req_p  requester ready.
REQ-011 data_o  output  flit_width_p  flit to the shared network link.
REQ-012 v_o  output  1  shared-link valid.
REQ-013 ready_and_i  input  1  shared-link ready.
REQ-014 grant_o  output  num_req_p  one-hot current owner; zero when no owner.
REQ-015 busy_o  output  1  high while a multi-flit packet is in flight.

Function
REQ-016 SHALL implement states IDLE and BUSY.
REQ-017 A handshake on a link SHALL be defined as valid and ready both high in the same cycle.
REQ-018 In IDLE, grant_o SHALL be computed combinationally as round-robin over v_i, starting at index (last_ptr+1) mod num_req_p.
REQ-019 In IDLE, data_o SHALL equal data_i of the granted requester, and v_o SHALL equal OR(v_i), with zero added latency.
REQ-020 ready_and_o[k] SHALL equal ready_and_i AND grant_o[k]; every other bit SHALL be 0.
REQ-021 In IDLE, a header handshake SHALL set last_ptr to the granted index.
REQ-022 On a header handshake with len==0, the block SHALL remain in IDLE.
REQ-023 On a header handshake with len>0, the block SHALL load the counter with len, latch the grant, and enter BUSY.
REQ-024 In BUSY, grant_o SHALL be the latched grant, independent of the other v_i.
REQ-025 In BUSY, v_o SHALL equal v_i of the owner.
REQ-026 In BUSY, each body handshake SHALL decrement the counter.
REQ-027 In BUSY, a handshake while counter==1 SHALL return the block to IDLE in the next cycle.
REQ-028 In IDLE, grant SHALL be re-evaluated every cycle until the header handshake; no commitment SHALL be made before the handshake.
REQ-029 When ready_and_i is low, no state, counter or pointer SHALL change.
REQ-030 Owner v_i low in BUSY SHALL produce a bubble (v_o=0) with the grant held.
REQ-031 busy_o SHALL be high exactly in BUSY.
REQ-032 The counter SHALL be len_width_p bits wide; len = 2^len_width_p-1 SHALL be supported without wrap.

Reset
REQ-033 On reset_i, state SHALL be IDLE, counter 0, and last_ptr num_req_p-1, so requester 0 has first priority.
REQ-034 During and in the cycle after reset, busy_o SHALL be 0, and grant_o, v_o and ready_and_o SHALL follow the IDLE rules only.
REQ-035 Reset asserted mid-packet SHALL abandon the packet; the abandoned packet is not resumed.

Configuration
REQ-036 With BP_ME_WH_ARB_FIXED_PRIO_EN defined, IDLE arbitration SHALL be fixed priority (lowest index wins) and last_ptr SHALL be unused.
REQ-037 Without BP_ME_WH_ARB_FIXED_PRIO_EN, the round-robin behaviour of REQ-018 and REQ-021 SHALL apply.
REQ-038 Both builds SHALL keep the BUSY locking behaviour identical.

Verification
REQ-039 After reset, v_i=2'b11, both len=0, ready_and_i=1 -> grants 0,1,0,1 on consecutive cycles; busy_o=0 throughout.
REQ-040 Requester 1 sends len=3 (4 flits) while requester 0 is valid from cycle 1 -> data_o carries all 4 flits of requester 1 contiguously, grant_o=2'b10 throughout, then requester 0 is granted.
REQ-041 Owner in BUSY with counter=2, ready_and_i low for 3 cycles -> counter stays 2, grant held, no ready_and_o to others, completes after ready returns.
REQ-042 Owner drops v_i for 2 cycles mid-packet -> v_o=0 for those cycles, busy_o=1, other requester not granted.
REQ-043 reset_i pulsed in BUSY with counter=5 -> next cycle IDLE, busy_o=0, requester 0 has first priority.
REQ-044 Fixed-priority build, v_i=2'b11, len=0 -> requester 0 granted every cycle; len=15 packet completes after 16 handshakes.
